// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and helpers for the data memory responder
// Purpose: FSM state encoding, access-length encodings and the byte-enable
//          helper used by data_mem_responder and its array.
// Ports:   none (package).
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  // Byte lanes touched by an access of 'len' bytes starting at byte 'off'.
  // Illegal lengths touch nothing.
  function automatic logic [3:0] byte_en(input logic [2:0] len, input logic [1:0] off);
    case (len)
      LEN_B:   byte_en = 4'b0001 << off;
      LEN_H:   byte_en = 4'b0011 << off;
      LEN_W:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - single-port word array with byte-enabled writes
// Purpose: DEPTH_WORDS x 32 storage. Synchronous byte-enabled write and
//          synchronous one-word read; the caller never issues both at once.
// Ports:   clk            clock
//          we, be[3:0]    write strobe and byte lanes
//          re             read strobe; rdata holds its value until the next re
//          addr[AW-1:0]   word index
//          wdata[31:0]    lane-positioned write data
//          rdata[31:0]    registered read data
module data_mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - LSU-facing memory responder with fixed latency
// Purpose: accepts one load/store at a time, checks it, commits or reads the
//          array LATENCY cycles later and holds the response until taken.
// Ports:   clk, rst                          clock, sync active-high reset
//          req_valid/req_ready               request handshake (ready is combinational)
//          req_addr, req_write, req_len,
//          req_wdata                         byte address, store flag, size, store data
//          resp_valid/resp_ready             response handshake
//          resp_rdata, resp_err              right-aligned load data, error flag
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [2:0]  req_len,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [2:0]  len_q, len_d;
  logic        err_q, err_d;

  logic        accept;
  logic        fire;
  logic        op_idle;
  logic [31:0] op_addr, op_wdata, op_rel;
  logic        op_write, op_err;
  logic [2:0]  op_len;
  logic        mem_we, mem_re;
  logic [31:0] mem_rdata, rd_shift, rd_mask;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // The array operation happens on the edge that enters RESP. With
  // LATENCY == 1 that is the acceptance edge itself, so the operands come
  // straight from the request; otherwise from the latched copy.
  always_comb begin
    op_idle  = (state_q == IDLE);
    op_addr  = op_idle ? req_addr  : addr_q;
    op_wdata = op_idle ? req_wdata : wdata_q;
    op_write = op_idle ? req_write : write_q;
    op_len   = op_idle ? req_len   : len_q;
    op_rel   = op_addr - ADDR_BASE;
    op_err   = !(op_len == LEN_B || op_len == LEN_H || op_len == LEN_W)
             || (op_len == LEN_H && op_addr[0] != 1'b0)
             || (op_len == LEN_W && op_addr[1:0] != 2'b00)
             || (op_rel >= SPAN);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    len_d   = len_q;
    err_d   = err_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          len_d   = req_len;
          err_d   = op_err;
          if (LATENCY == 1) begin
            state_d = RESP;
            fire    = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    write_q <= write_d;
    len_q   <= len_d;
    err_q   <= err_d;
  end

  // Reset on the commit edge must suppress the store as well as the response.
  assign mem_we = fire && op_write && !op_err && !rst;
  assign mem_re = fire && !op_write && !op_err && !rst;

  data_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .be   (byte_en(op_len, op_addr[1:0])),
    .re   (mem_re),
    .addr (op_rel[AW+1:2]),
    .wdata(op_wdata << {op_addr[1:0], 3'b000}),
    .rdata(mem_rdata)
  );

  // The array output only changes on a read strobe, which cannot occur in
  // RESP, so the aligned data is stable for the whole response.
  always_comb begin
    rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};
    case (len_q)
      LEN_B:   rd_mask = 32'h0000_00FF;
      LEN_H:   rd_mask = 32'h0000_FFFF;
      default: rd_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !write_q && !err_q) ? (rd_shift & rd_mask) : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed table-driven bench for data_mem_responder
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic [2:0]  vld;
  logic [2:0]  rdy;
  logic [31:0] req_addr;
  logic        req_write;
  logic [2:0]  req_len;
  logic [31:0] req_wdata;
  logic [2:0]  rv;
  logic        resp_ready;
  logic [31:0] rdat [3];
  logic [2:0]  er;

  int checks;
  int failures;

  // Instance 0: LATENCY 2 (main), 1: LATENCY 1, 2: LATENCY 4.
  data_mem_responder #(.LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_addr(req_addr), .req_write(req_write), .req_len(req_len), .req_wdata(req_wdata),
    .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_rdata(rdat[0]), .resp_err(er[0]));

  data_mem_responder #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_addr(req_addr), .req_write(req_write), .req_len(req_len), .req_wdata(req_wdata),
    .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_rdata(rdat[1]), .resp_err(er[1]));

  data_mem_responder #(.LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy[2]),
    .req_addr(req_addr), .req_write(req_write), .req_len(req_len), .req_wdata(req_wdata),
    .resp_valid(rv[2]), .resp_ready(resp_ready), .resp_rdata(rdat[2]), .resp_err(er[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        w;
    logic [2:0]  len;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // One full transaction with resp_ready high. lat counts cycles from the
  // acceptance cycle to the first cycle showing resp_valid.
  task automatic txn(input int sel, input logic [31:0] a, input logic w, input logic [2:0] l,
                     input logic [31:0] d, output logic [31:0] rd, output logic e, output int lat);
    req_addr  = a;
    req_write = w;
    req_len   = l;
    req_wdata = d;
    for (int n = 0; n < 20 && !rdy[sel]; n++) begin
      @(posedge clk); #1;
    end
    chk("accept_ready", {31'b0, rdy[sel]}, 32'd1);
    vld[sel] = 1'b1;
    @(posedge clk); #1;
    vld[sel] = 1'b0;
    lat = 1;
    while (!rv[sel] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdat[sel];
    e  = er[sel];
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;

    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    vld        = 3'b000;
    resp_ready = 1'b1;
    req_addr   = 32'h0;
    req_write  = 1'b0;
    req_len    = 3'd4;
    req_wdata  = 32'h0;

    //           addr          w     len   wdata          exp_rdata      err
    tbl.push_back('{32'h8000_0010, 1'b1, 3'd4, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
    tbl.push_back('{32'h8000_0010, 1'b0, 3'd4, 32'h0,        32'hDEAD_BEEF, 1'b0});
    tbl.push_back('{32'h8000_0010, 1'b1, 3'd4, 32'h1122_3344, 32'h0000_0000, 1'b0});
    tbl.push_back('{32'h8000_0013, 1'b1, 3'd1, 32'h0000_00AA, 32'h0000_0000, 1'b0});
    tbl.push_back('{32'h8000_0010, 1'b0, 3'd4, 32'h0,        32'hAA22_3344, 1'b0});
    tbl.push_back('{32'h8000_0013, 1'b0, 3'd1, 32'h0,        32'h0000_00AA, 1'b0});
    tbl.push_back('{32'h8000_0012, 1'b0, 3'd2, 32'h0,        32'h0000_AA22, 1'b0});
    tbl.push_back('{32'h8000_0010, 1'b0, 3'd2, 32'h0,        32'h0000_3344, 1'b0});
    tbl.push_back('{32'h8000_0011, 1'b1, 3'd1, 32'hFFFF_FF55, 32'h0000_0000, 1'b0});
    tbl.push_back('{32'h8000_0010, 1'b0, 3'd4, 32'h0,        32'hAA22_5544, 1'b0});
    tbl.push_back('{32'h8000_0FFC, 1'b1, 3'd4, 32'hCAFE_F00D, 32'h0000_0000, 1'b0});
    tbl.push_back('{32'h8000_0002, 1'b0, 3'd4, 32'h0,        32'h0000_0000, 1'b1});
    tbl.push_back('{32'h8000_1000, 1'b1, 3'd4, 32'h1234_5678, 32'h0000_0000, 1'b1});
    tbl.push_back('{32'h8000_0FFC, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
    tbl.push_back('{32'h7FFF_FFFC, 1'b0, 3'd4, 32'h0,        32'h0000_0000, 1'b1});
    tbl.push_back('{32'h8000_0FFD, 1'b1, 3'd2, 32'h0000_FFFF, 32'h0000_0000, 1'b1});
    tbl.push_back('{32'h8000_0FFC, 1'b0, 3'd4, 32'h0,        32'hCAFE_F00D, 1'b0});
    tbl.push_back('{32'h8000_0FFE, 1'b1, 3'd2, 32'h0000_BEEF, 32'h0000_0000, 1'b0});
    tbl.push_back('{32'h8000_0FFC, 1'b0, 3'd4, 32'h0,        32'hBEEF_F00D, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {29'b0, rdy}, 32'd0);
    chk("rst_resp_valid", {29'b0, rv}, 32'd0);
    chk("rst_resp_rdata", rdat[0], 32'h0);
    chk("rst_resp_err", {29'b0, er}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", {29'b0, rdy}, 32'd7);

    for (int i = 0; i < tbl.size(); i++) begin
      txn(0, tbl[i].addr, tbl[i].w, tbl[i].len, tbl[i].wd, rd, e, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, tbl[i].exp_err});
      chk($sformatf("vec%0d_latency", i), lat, 32'd2);
    end

    // Backpressure: response held 5 cycles while a second request waits.
    resp_ready = 1'b0;
    req_addr   = 32'h8000_0010;
    req_write  = 1'b0;
    req_len    = 3'd4;
    vld[0]     = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h8000_0FFC;
    @(posedge clk); #1;
    chk("bp_valid_first", {31'b0, rv[0]}, 32'd1);
    chk("bp_rdata_first", rdat[0], 32'hAA22_5544);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid_c%0d", c), {31'b0, rv[0]}, 32'd1);
      chk($sformatf("bp_rdata_c%0d", c), rdat[0], 32'hAA22_5544);
      chk($sformatf("bp_req_ready_c%0d", c), {31'b0, rdy[0]}, 32'd0);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_ready_before_hs", {31'b0, rdy[0]}, 32'd0);
    @(posedge clk); #1;
    chk("bp_valid_after_hs", {31'b0, rv[0]}, 32'd0);
    chk("bp_req_ready_after_hs", {31'b0, rdy[0]}, 32'd1);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    chk("bp_second_accepted", {31'b0, rdy[0]}, 32'd0);
    @(posedge clk); #1;
    chk("bp_second_valid", {31'b0, rv[0]}, 32'd1);
    chk("bp_second_rdata", rdat[0], 32'hBEEF_F00D);
    @(posedge clk); #1;

    // Latency sweep on the LATENCY=1 and LATENCY=4 instances.
    txn(1, 32'h8000_0040, 1'b1, 3'd4, 32'h55AA_55AA, rd, e, lat);
    chk("l1_store_latency", lat, 32'd1);
    txn(1, 32'h8000_0040, 1'b0, 3'd4, 32'h0, rd, e, lat);
    chk("l1_load_latency", lat, 32'd1);
    chk("l1_load_rdata", rd, 32'h55AA_55AA);
    txn(2, 32'h8000_0040, 1'b1, 3'd4, 32'h0F1E_2D3C, rd, e, lat);
    chk("l4_store_latency", lat, 32'd4);
    txn(2, 32'h8000_0041, 1'b0, 3'd1, 32'h0, rd, e, lat);
    chk("l4_load_latency", lat, 32'd4);
    chk("l4_load_rdata", rd, 32'h0000_002D);

    // Reset while a store is in WAIT: the store must be dropped.
    txn(0, 32'h8000_0020, 1'b1, 3'd4, 32'h1111_1111, rd, e, lat);
    req_addr  = 32'h8000_0020;
    req_write = 1'b1;
    req_len   = 3'd4;
    req_wdata = 32'h1234_5678;
    vld[0]    = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    rst    = 1'b1;
    @(posedge clk); #1;
    chk("rst_wait_valid", {31'b0, rv[0]}, 32'd0);
    chk("rst_wait_ready_in_rst", {31'b0, rdy[0]}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_wait_ready_after", {31'b0, rdy[0]}, 32'd1);
    txn(0, 32'h8000_0020, 1'b0, 3'd4, 32'h0, rd, e, lat);
    chk("rst_wait_old_value", rd, 32'h1111_1111);
    chk("rst_wait_load_err", {31'b0, e}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
